// File: rtl/alu_ctrl_exec_pipe.sv
// alu_ctrl_exec_pipe: two-stage EX pipe, stage 1 decodes ALUOp/funct, stage 2 executes RV32I ops.
// Optional ALU_ILLEGAL_CNT_EN adds illegal_cnt, a saturating count of delivered illegal results.
module alu_ctrl_exec_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_ILLEGAL_CNT_EN
  , output logic [7:0]     illegal_cnt
`endif
);
  localparam int SH = $clog2(WIDTH);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
                         OP_XOR = 4'b0011, OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SRA = 4'b0111,
                         OP_SLT = 4'b1000, OP_SLTU = 4'b1001, OP_ILL = 4'b1111;
  logic             r_s1_valid, r_s2_valid;
  logic [3:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a, r_s1_b, r_result;
  logic [TAG_W-1:0] r_s1_tag, r_tag;
  logic             r_zero, r_illegal;
  logic             w_s2_free, w_adv, w_acc;
  logic [3:0]       w_op;
  logic [SH-1:0]    w_shamt;
  logic [WIDTH-1:0] w_res;
  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_adv     = r_s1_valid && w_s2_free;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_acc     = in_valid && in_ready;
  assign w_shamt   = r_s1_b[SH-1:0];
  always_comb begin
    w_op = OP_ILL;
    if (alu_op == 2'b00) w_op = OP_ADD;
    else if (alu_op == 2'b01) w_op = OP_SUB;
    else if (alu_op == 2'b10)
      case (funct)
        4'b0000: w_op = OP_ADD;
        4'b1000: w_op = OP_SUB;
        4'b0001: w_op = OP_SLL;
        4'b0010: w_op = OP_SLT;
        4'b0011: w_op = OP_SLTU;
        4'b0100: w_op = OP_XOR;
        4'b0101: w_op = OP_SRL;
        4'b1101: w_op = OP_SRA;
        4'b0110: w_op = OP_OR;
        4'b0111: w_op = OP_AND;
        default: w_op = OP_ILL;
      endcase
    else
      // I-type: funct[3] only matters for shifts
      case (funct[2:0])
        3'b000:  w_op = OP_ADD;
        3'b001:  w_op = funct[3] ? OP_ILL : OP_SLL;
        3'b010:  w_op = OP_SLT;
        3'b011:  w_op = OP_SLTU;
        3'b100:  w_op = OP_XOR;
        3'b101:  w_op = funct[3] ? OP_SRA : OP_SRL;
        3'b110:  w_op = OP_OR;
        default: w_op = OP_AND;
      endcase
  end
  always_comb begin
    w_res = '0;
    case (r_s1_op)
      OP_AND:  w_res = r_s1_a & r_s1_b;
      OP_OR:   w_res = r_s1_a | r_s1_b;
      OP_XOR:  w_res = r_s1_a ^ r_s1_b;
      OP_ADD:  w_res = r_s1_a + r_s1_b;
      OP_SUB:  w_res = r_s1_a - r_s1_b;
      OP_SLL:  w_res = r_s1_a << w_shamt;
      OP_SRL:  w_res = r_s1_a >> w_shamt;
      OP_SRA:  w_res = $signed(r_s1_a) >>> w_shamt;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(r_s1_a) < $signed(r_s1_b)};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, r_s1_a < r_s1_b};
      default: w_res = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_AND;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_illegal  <= 1'b0;
      r_tag      <= '0;
    end else begin
      if (flush) r_s1_valid <= 1'b0;
      else if (in_ready) r_s1_valid <= in_valid;
      if (w_acc) begin
        r_s1_op  <= w_op;
        r_s1_a   <= opa;
        r_s1_b   <= opb;
        r_s1_tag <= in_tag;
      end
      if (flush) r_s2_valid <= 1'b0;
      else if (w_s2_free) r_s2_valid <= r_s1_valid;
      // data only moves on advance, so a stalled output holds stable
      if (w_adv) begin
        r_result  <= w_res;
        r_zero    <= w_res == '0;
        r_illegal <= r_s1_op == OP_ILL;
        r_tag     <= r_s1_tag;
      end
    end
  end
  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
  assign out_tag   = r_tag;
`ifdef ALU_ILLEGAL_CNT_EN
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (r_s2_valid && out_ready && r_illegal && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
  end
  assign illegal_cnt = r_cnt;
`endif
endmodule

// File: tb/tb_alu_ctrl_exec_pipe.sv
// tb_alu_ctrl_exec_pipe: vector table, directed pipeline sequences and a random scoreboard run.
module tb_alu_ctrl_exec_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]  alu_op = '0;
  logic [3:0]  funct = '0;
  logic [31:0] opa = '0, opb = '0;
  logic [4:0]  in_tag = '0;
  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result;
  logic [4:0]  out_tag;
  logic [7:0]  illegal_cnt;
  int checks = 0, failures = 0;

  alu_ctrl_exec_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .opa(opa), .opb(opb), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .illegal(illegal), .out_tag(out_tag)
`ifdef ALU_ILLEGAL_CNT_EN
    , .illegal_cnt(illegal_cnt)
`endif
  );
`ifndef ALU_ILLEGAL_CNT_EN
  assign illegal_cnt = 8'd0;
`endif

  always #5 clk = ~clk;

  typedef struct { logic [31:0] r; logic ill; logic [4:0] tag; } exp_t;
  typedef struct { logic [1:0] op; logic [3:0] f; logic [31:0] a, b, r; logic ill; } vec_t;
  exp_t q[$];
  int cnt_m = 0;
  logic stall_prev = 1'b0;
  logic [31:0] prev_r;
  logic [4:0] prev_tag;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Behavioural model: decides the RV32I meaning of the request, then computes it.
  function automatic exp_t ref_alu(logic [1:0] op, logic [3:0] f, logic [31:0] a, logic [31:0] b,
                                   logic [4:0] tag);
    exp_t e;
    string k;
    if (op == 2'd0) k = "add";
    else if (op == 2'd1) k = "sub";
    else begin
      case (f[2:0])
        3'd0: k = "add"; 3'd1: k = "sll"; 3'd2: k = "slt"; 3'd3: k = "sltu";
        3'd4: k = "xor"; 3'd5: k = f[3] ? "sra" : "srl"; 3'd6: k = "or"; default: k = "and";
      endcase
      if (op == 2'd2 && f[3] && f[2:0] == 3'd0) k = "sub";
      else if (op == 2'd2 && f[3] && f[2:0] != 3'd5) k = "ill";
      if (op == 2'd3 && f[2:0] == 3'd1 && f[3]) k = "ill";
    end
    e.tag = tag;
    e.ill = (k == "ill");
    case (k)
      "add":  e.r = a + b;
      "sub":  e.r = a - b;
      "sll":  e.r = a << b[4:0];
      "srl":  e.r = a >> b[4:0];
      "sra":  e.r = $signed(a) >>> b[4:0];
      "slt":  e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      "sltu": e.r = (a < b) ? 32'd1 : 32'd0;
      "xor":  e.r = a ^ b;
      "or":   e.r = a | b;
      "and":  e.r = a & b;
      default: e.r = 32'd0;
    endcase
    return e;
  endfunction

  // One clock: scoreboard events sampled at the falling edge, then the rising edge passes.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (stall_prev && out_valid) begin
      chk("hold_result", result, prev_r);
      chk("hold_tag", {27'd0, out_tag}, {27'd0, prev_tag});
    end
    stall_prev = out_valid && !out_ready;
    prev_r = result;
    prev_tag = out_tag;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("sb_result", result, e.r);
        chk("sb_illegal", {31'd0, illegal}, {31'd0, e.ill});
        chk("sb_zero", {31'd0, zero}, {31'd0, e.r == 32'd0});
        chk("sb_tag", {27'd0, out_tag}, {27'd0, e.tag});
        if (e.ill && cnt_m < 255) cnt_m++;
      end
    end
    if (flush) q.delete();
    if (in_valid && in_ready && !flush) q.push_back(ref_alu(alu_op, funct, opa, opb, in_tag));
    @(posedge clk);
    #1;
`ifdef ALU_ILLEGAL_CNT_EN
    chk("illegal_cnt", {24'd0, illegal_cnt}, cnt_m);
`endif
  endtask

  task automatic drive(logic [1:0] op, logic [3:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] t);
    alu_op = op; funct = f; opa = a; opb = b; in_tag = t; in_valid = 1'b1;
  endtask

  vec_t vt[18];
  int acc;

  initial begin
    vt[0]  = '{2'b10, 4'b0000, 32'd5,        32'd7,        32'd12,       1'b0};
    vt[1]  = '{2'b10, 4'b1000, 32'd3,        32'd3,        32'd0,        1'b0};
    vt[2]  = '{2'b10, 4'b1101, 32'h80000000, 32'd4,        32'hF8000000, 1'b0};
    vt[3]  = '{2'b10, 4'b0011, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0};
    vt[4]  = '{2'b11, 4'b1101, 32'hF0,       32'd2,        32'h3C,       1'b0};
    vt[5]  = '{2'b11, 4'b1001, 32'd1,        32'd1,        32'd0,        1'b1};
    vt[6]  = '{2'b00, 4'b1111, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    vt[7]  = '{2'b01, 4'b0101, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0};
    vt[8]  = '{2'b10, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vt[9]  = '{2'b10, 4'b0001, 32'd1,        32'd33,       32'd2,        1'b0};
    vt[10] = '{2'b10, 4'b1001, 32'd7,        32'd7,        32'd0,        1'b1};
    vt[11] = '{2'b11, 4'b1000, 32'd10,       32'd3,        32'd13,       1'b0};
    vt[12] = '{2'b10, 4'b0101, 32'h80000000, 32'd31,       32'd1,        1'b0};
    vt[13] = '{2'b10, 4'b0110, 32'hF0,       32'h0F,       32'hFF,       1'b0};
    vt[14] = '{2'b10, 4'b0111, 32'hF0,       32'h3C,       32'h30,       1'b0};
    vt[15] = '{2'b10, 4'b0100, 32'hFF,       32'h0F,       32'hF0,       1'b0};
    vt[16] = '{2'b11, 4'b0001, 32'd1,        32'd36,       32'h10,       1'b0};
    vt[17] = '{2'b11, 4'b0010, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0};
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_cnt", {24'd0, illegal_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    foreach (vt[i]) begin
      drive(vt[i].op, vt[i].f, vt[i].a, vt[i].b, 5'(i));
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_lat1_valid", i), {31'd0, out_valid}, 32'd0);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), result, vt[i].r);
      chk($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, vt[i].r == 32'd0});
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, vt[i].ill});
      chk($sformatf("v%0d_tag", i), {27'd0, out_tag}, i);
    end
    step();
    // back-to-back stream
    drive(2'b10, 4'b1000, 32'd3, 32'd3, 5'd1);
    step();
    chk("b2b_ready0", {31'd0, in_ready}, 32'd1);
    drive(2'b10, 4'b1101, 32'h80000000, 32'd4, 5'd2);
    step();
    chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
    chk("b2b_r0", result, 32'd0);
    chk("b2b_z0", {31'd0, zero}, 32'd1);
    drive(2'b10, 4'b0011, 32'd1, 32'hFFFFFFFF, 5'd3);
    step();
    in_valid = 1'b0;
    chk("b2b_ready2", {31'd0, in_ready}, 32'd1);
    chk("b2b_r1", result, 32'hF8000000);
    chk("b2b_v1", {31'd0, out_valid}, 32'd1);
    step();
    chk("b2b_r2", result, 32'd1);
    chk("b2b_v2", {31'd0, out_valid}, 32'd1);
    step();
    // backpressure: 3 offers over 5 stalled cycles
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(2'b00, 4'b0000, 32'd100 + acc, 32'd0, 5'd10 + 5'(acc));
      if (in_ready) acc++;
      step();
      if (c >= 1) begin
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_result", result, 32'd100);
        chk("bp_tag", {27'd0, out_tag}, 32'd10);
      end
    end
    chk("bp_accepted", acc, 32'd2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_second", result, 32'd101);
    chk("bp_second_tag", {27'd0, out_tag}, 32'd11);
    step();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    // flush with both stages full and a new request present
    drive(2'b00, 4'b0000, 32'd1, 32'd1, 5'd1);
    step();
    drive(2'b00, 4'b0000, 32'd2, 32'd2, 5'd2);
    step();
    chk("fl_full", result, 32'd2);
    drive(2'b00, 4'b0000, 32'd3, 32'd3, 5'd3);
    flush = 1'b1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    flush = 1'b0;
    chk("fl_killed", {31'd0, out_valid}, 32'd0);
    drive(2'b00, 4'b0000, 32'd4, 32'd4, 5'd4);
    step();
    in_valid = 1'b0;
    chk("fl_discard", {31'd0, out_valid}, 32'd0);
    step();
    chk("fl_after_valid", {31'd0, out_valid}, 32'd1);
    chk("fl_after_result", result, 32'd8);
    chk("fl_after_tag", {27'd0, out_tag}, 32'd4);
    step();
`ifdef ALU_ILLEGAL_CNT_EN
    for (int n = 0; n < 300; n++) begin
      drive(2'b10, 4'b1001, $urandom, $urandom, 5'(n));
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("cnt_saturated", {24'd0, illegal_cnt}, 32'd255);
`endif
    // async reset mid-stream
    drive(2'b00, 4'b0000, 32'd5, 32'd5, 5'd7);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_result", result, 32'd0);
    chk("ar_tag", {27'd0, out_tag}, 32'd0);
    chk("ar_cnt", {24'd0, illegal_cnt}, 32'd0);
    q.delete();
    cnt_m = 0;
    stall_prev = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
    for (int n = 0; n < 3000; n++) begin
      alu_op = 2'($urandom);
      funct = 4'($urandom);
      opa = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      opb = ($urandom_range(0, 3) == 0) ? opa : $urandom;
      in_tag = 5'($urandom);
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 19) == 0;
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("final_drain", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_exec_pipe.md
Name: alu_ctrl_exec_pipe

Overview:
- Parametrised successor to the combinational ALU-control decoder, for the EX stage of the pipelined core.
- Stage 1 decodes ALUOp/Funct into a registered 4-bit Operation and captures the operands. Stage 2 executes the full RV32I integer op set and registers the result.
- Valid/ready handshake on both sides. Synchronous flush for branch mispredict.

Parameters:
- WIDTH, 32, operand/result width; power of 2, >= 8.
- TAG_W, 5, width of the sideband tag (destination register index) carried alongside data.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of both stages.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  block can accept this cycle.
- alu_op  in  2  00 add, 01 sub (branch), 10 R-type, 11 I-type.
- funct  in  4  {funct7[5], funct3}.
- opa  in  WIDTH  operand A.
- opb  in  WIDTH  operand B; shift amount = opb[log2(WIDTH)-1:0].
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- result  out  WIDTH  ALU result.
- zero  out  1  result == 0.
- illegal  out  1  undecodable funct for this alu_op.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, result=0, zero=0, illegal=0, out_tag=0, stage-1 Operation=0000. in_ready=1 after release.

Operation encoding (stage-1 register):
- 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL, 0101 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1111 ILLEGAL.

Decode:
- alu_op=00 -> ADD, funct ignored.
- alu_op=01 -> SUB, funct ignored.
- alu_op=10 (R-type):
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - All other codes -> ILLEGAL.
- alu_op=11 (I-type): funct[3] ignored except:
  - funct3=101: funct[3] selects SRL (0) or SRA (1).
  - funct3=001 with funct[3]=1 -> ILLEGAL.
  - No SUB in this mode: x000 -> ADD.
- Decode is fully specified for every input, with no latches.

Execute (stage 2):
- Arithmetic is modulo 2^WIDTH.
- SLT is signed compare, SLTU unsigned; both produce zero-extended 0/1.
- SRA sign-fills.
- ILLEGAL -> result 0, illegal=1, zero=1.

Pipeline and handshake:
- s2_free = !s2_valid || out_ready.
- s1 advances to s2 when s1_valid && s2_free.
- in_ready = !s1_valid || s2_free (combinational, no dependency on in_valid).
- Input accepted on in_valid && in_ready.
- Latency: 2 cycles from accept to out_valid when there is no backpressure. Throughput: 1 per cycle.
- While out_valid && !out_ready: result, zero, illegal and out_tag hold stable.
- Stage 1 holds when s2 is stalled.
- No bubble is inserted when out_ready is high.

Flush and reset:
- flush=1 at a clock edge: s1_valid=0 and s2_valid=0. Any input accepted in the same cycle is discarded. flush has priority over load.
- in_ready is unaffected by flush.
- Data registers may keep stale values while invalid.
- Reset asserted mid-transfer: outputs go to reset values immediately; no partial result survives.

Optional Feature:
- Macro: ALU_ILLEGAL_CNT_EN.
- Defined:
  - Adds output port illegal_cnt [7:0].
  - Increments by 1 on each transfer (out_valid && out_ready) with illegal=1.
  - Saturates at 255; never wraps.
  - Resets to 0 on rst_n; flush does not clear it.
- Undefined: port absent; no counter logic.

Test Plan:
- Reset release, in_valid=1, alu_op=10, funct=0000, opa=5, opb=7, out_ready=1 -> out_valid rises 2 cycles after accept; result=12, zero=0, illegal=0.
- Back-to-back stream: R-type SUB 3-3, then SRA 0x80000000>>4, then SLTU 1<0xFFFFFFFF, one per cycle -> results 0 (zero=1), 0xF8000000, 1 on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0 for 5 cycles with 3 inputs offered -> 2 accepted, then in_ready=0; outputs stable throughout. After release, all 2 results delivered in order with correct tags and no loss or duplication.
- I-type: alu_op=11, funct=1101, opa=0xF0, opb=2 -> SRA result 0x3C. funct=1001 -> illegal=1, result 0.
- Flush: flush asserted while both stages are valid and in_valid=1 -> next cycle out_valid=0; the following accepted op emerges normally 2 cycles later.
- ALU_ILLEGAL_CNT_EN defined: 300 illegal ops -> illegal_cnt=255. Async reset mid-stream -> all outputs and illegal_cnt go to 0 immediately.
